ap_ctrl_perf_monitor: RTL and testbench
=======================================

// Module: ap_ctrl_perf_monitor
// PURPOSE
//  Synthesizable multi-channel performance monitor for HLS ap_ctrl_hs/ap_ctrl_chain blocks.
//  Each channel watches one kernel/sub-function handshake (ap_start/ap_ready/ap_done/
//  ap_continue) plus a loop iteration-end strobe, and keeps saturating counters.
//  Results are read through a registered channel/field mux. Sits beside the fir top and its pipelined loops.
// PARAMETERS
//  N_CH    4   number of monitored channels (>=1)
//  CNT_W   32  width of every counter and of rd_data (>=8)
//  MAX_OUT 4   max outstanding transactions per channel (ap_ctrl_chain overlap), >=1
// PORTS
//  clock        in   1              rising-edge clock
//  reset        in   1              asynchronous, active-high reset
//  finish       in   1              freeze all counters from next cycle onward (sticky until reset/clear)
//  clear        in   1              synchronous clear of all counters, states, frozen flag
//  ap_start     in   N_CH           per-channel ap_start
//  ap_ready     in   N_CH           per-channel ap_ready
//  ap_done      in   N_CH           per-channel ap_done
//  ap_continue  in   N_CH           per-channel ap_continue (tie 1 for ap_ctrl_hs)
//  iter_end     in   N_CH           per-channel loop iteration-complete strobe
//  rd_ch        in   max(1,$clog2(N_CH))  channel select
//  rd_field     in   3              field select (see BEHAVIOUR)
//  rd_data      out  CNT_W          selected counter, registered
//  active       out  N_CH           channel state != IDLE
//  overflow     out  N_CH           sticky: any counter of channel saturated or outstanding overrun
// BEHAVIOUR
//  Reset (async) / clear (sync, priority over everything but reset): all counters 0, states IDLE,
//   rd_data 0, active 0, overflow 0, frozen 0. clear and finish same cycle -> clear wins.
//  Events per channel, sampled at posedge: acc = start&ready; cmp = done&continue; stl = done&~continue.
//  States per channel: IDLE (outst==0), BUSY (outst>0, no stl), HOLD (stl this cycle).
//   IDLE -acc-> BUSY; BUSY -stl-> HOLD; HOLD -cmp-> BUSY if outst-1>0 else IDLE;
//   BUSY -cmp-> IDLE when outst becomes 0. acc&cmp same cycle: outst unchanged, state BUSY.
//  outst: +1 on acc, -1 on cmp. acc at outst==MAX_OUT -> outst holds, overflow set.
//   cmp at outst==0 -> ignored (no count), overflow set.
//  Fields (rd_field):
//   0 txn_count     +1 per acc
//   1 done_count    +1 per cmp
//   2 last_latency  cycles from acc to cmp, measured only for acc taken at outst==0 (timer starts 1
//                   on the cycle after acc; acc and cmp on same edge at outst==0 gives 0)
//   3 max_latency   max of all last_latency updates
//   4 last_interval cycles between consecutive acc edges (first acc leaves it 0)
//   5 stall_cycles  +1 per cycle with stl
//   6 iter_count    +1 per cycle with iter_end
//   7 busy_cycles   +1 per cycle state != IDLE
//  All counters saturate at 2^CNT_W-1 (no wrap); reaching saturation sets overflow.
//  Latency/interval timers likewise saturate.
//  finish=1 at edge k: that edge's events still count; from edge k+1 nothing updates (frozen).
//  Read: rd_data at edge t+1 = field(rd_ch,rd_field) value after edge t updates
//   (1-cycle latency, always valid). rd_ch>=N_CH -> rd_data 0.
//  Inputs from X during reset are ignored; reset mid-operation aborts all in-flight measurement.
// TESTING
//  1 N_CH=2: ch0 acc at cyc 10, cmp at cyc 25 -> txn=1, done=1, last_lat=15, max_lat=15, busy=15.
//  2 ch1 three acc every 3 cycles, continue=0 for 4 cycles at first done -> last_interval=3,
//    stall_cycles=4, state HOLD then BUSY, active[1]=1 until final cmp.
//  3 MAX_OUT=2: three acc without cmp -> outst=2, overflow[ch]=1, txn_count=3.
//  4 CNT_W=8: 300 iter_end pulses -> iter_count=255, overflow=1; other channel unaffected.
//  5 finish same edge as acc -> txn counted; later acc/iter_end ignored; clear -> all 0, counting resumes.
//  6 async reset asserted mid-BUSY between edges -> active, counters, rd_data 0 immediately;
//    rd_ch=N_CH -> rd_data 0.

Source files
------------

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor
// Per-channel performance counters for HLS ap_ctrl_hs / ap_ctrl_chain handshakes.
// Every channel tracks outstanding transactions, latency, accept interval, stalls,
// loop iterations and busy time. All counters saturate. Results are read through
// a registered channel/field mux with one cycle of latency.
//
// state | meaning
// IDLE  | no outstanding transaction
// BUSY  | at least one transaction outstanding, no stall this cycle
// HOLD  | outstanding and ap_done held back by ap_continue=0

module ap_ctrl_perf_monitor #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int MAX_OUT = 4,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int OW     = $clog2(MAX_OUT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic              clear,
    input  logic [N_CH-1:0]   ap_start,
    input  logic [N_CH-1:0]   ap_ready,
    input  logic [N_CH-1:0]   ap_done,
    input  logic [N_CH-1:0]   ap_continue,
    input  logic [N_CH-1:0]   iter_end,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_field,
    output logic [CNT_W-1:0]  rd_data,
    output logic [N_CH-1:0]   active,
    output logic [N_CH-1:0]   overflow
);

    localparam int F_TXN     = 0;
    localparam int F_DONE    = 1;
    localparam int F_LASTLAT = 2;
    localparam int F_MAXLAT  = 3;
    localparam int F_LASTINT = 4;
    localparam int F_STALL   = 5;
    localparam int F_ITER    = 6;
    localparam int F_BUSY    = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q   [N_CH];
    state_t             state_d   [N_CH];
    logic [OW-1:0]      outst_q   [N_CH];
    logic [OW-1:0]      outst_d   [N_CH];
    logic [CNT_W-1:0]   cnt_q     [N_CH][8];
    logic [CNT_W-1:0]   cnt_d     [N_CH][8];
    logic [CNT_W-1:0]   lat_tmr_q [N_CH];
    logic [CNT_W-1:0]   lat_tmr_d [N_CH];
    logic [CNT_W-1:0]   int_tmr_q [N_CH];
    logic [CNT_W-1:0]   int_tmr_d [N_CH];
    logic [N_CH-1:0]    lat_run_q, lat_run_d;
    logic [N_CH-1:0]    acc_seen_q, acc_seen_d;
    logic [N_CH-1:0]    overflow_q, overflow_d;
    logic               frozen_q, frozen_d;
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;

    logic [N_CH-1:0]    acc, cmp, stl;

    assign acc = ap_start & ap_ready;
    assign cmp = ap_done & ap_continue;
    assign stl = ap_done & ~ap_continue;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-state for handshake tracking, counters, timers and the read mux
    always_comb begin
        state_d    = state_q;
        outst_d    = outst_q;
        cnt_d      = cnt_q;
        lat_tmr_d  = lat_tmr_q;
        int_tmr_d  = int_tmr_q;
        lat_run_d  = lat_run_q;
        acc_seen_d = acc_seen_q;
        overflow_d = overflow_q;
        frozen_d   = frozen_q;

        if (int'(rd_ch) < N_CH) begin
            rd_data_d = cnt_q[rd_ch][rd_field];
        end else begin
            rd_data_d = '0;
        end

        if (!frozen_q) begin
            frozen_d = finish;
            for (int c = 0; c < N_CH; c++) begin
                // a completion with nothing outstanding is only legal when paired with an accept
                if (acc[c] && cmp[c]) begin
                    outst_d[c] = outst_q[c];
                end else if (acc[c]) begin
                    if (outst_q[c] == OW'(MAX_OUT)) begin
                        overflow_d[c] = 1'b1;
                    end else begin
                        outst_d[c] = outst_q[c] + OW'(1);
                    end
                end else if (cmp[c]) begin
                    if (outst_q[c] == '0) begin
                        overflow_d[c] = 1'b1;
                    end else begin
                        outst_d[c] = outst_q[c] - OW'(1);
                    end
                end

                if (acc[c]) begin
                    cnt_d[c][F_TXN] = sat_inc(cnt_q[c][F_TXN]);
                end
                if (cmp[c] && (acc[c] || outst_q[c] != '0)) begin
                    cnt_d[c][F_DONE] = sat_inc(cnt_q[c][F_DONE]);
                end
                if (stl[c]) begin
                    cnt_d[c][F_STALL] = sat_inc(cnt_q[c][F_STALL]);
                end
                if (iter_end[c]) begin
                    cnt_d[c][F_ITER] = sat_inc(cnt_q[c][F_ITER]);
                end
                if (state_q[c] != ST_IDLE) begin
                    cnt_d[c][F_BUSY] = sat_inc(cnt_q[c][F_BUSY]);
                end

                // latency is only tracked for a transaction that starts from idle
                if (lat_run_q[c]) begin
                    lat_tmr_d[c] = sat_inc(lat_tmr_q[c]);
                end
                if (acc[c] && outst_q[c] == '0) begin
                    if (cmp[c]) begin
                        cnt_d[c][F_LASTLAT] = '0;
                    end else begin
                        lat_run_d[c] = 1'b1;
                        lat_tmr_d[c] = '0;
                    end
                end else if (cmp[c] && lat_run_q[c]) begin
                    cnt_d[c][F_LASTLAT] = sat_inc(lat_tmr_q[c]);
                    if (cnt_d[c][F_LASTLAT] > cnt_q[c][F_MAXLAT]) begin
                        cnt_d[c][F_MAXLAT] = cnt_d[c][F_LASTLAT];
                    end
                    lat_run_d[c] = 1'b0;
                end

                if (acc_seen_q[c]) begin
                    int_tmr_d[c] = sat_inc(int_tmr_q[c]);
                end
                if (acc[c]) begin
                    if (acc_seen_q[c]) begin
                        cnt_d[c][F_LASTINT] = sat_inc(int_tmr_q[c]);
                    end
                    int_tmr_d[c]  = '0;
                    acc_seen_d[c] = 1'b1;
                end

                if ((&cnt_d[c][F_TXN]) || (&cnt_d[c][F_DONE]) || (&cnt_d[c][F_STALL]) ||
                    (&cnt_d[c][F_ITER]) || (&cnt_d[c][F_BUSY])) begin
                    overflow_d[c] = 1'b1;
                end

                if (outst_d[c] == '0) begin
                    state_d[c] = ST_IDLE;
                end else if (stl[c]) begin
                    state_d[c] = ST_HOLD;
                end else begin
                    state_d[c] = ST_BUSY;
                end
            end
        end

        if (clear) begin
            for (int c = 0; c < N_CH; c++) begin
                state_d[c]   = ST_IDLE;
                outst_d[c]   = '0;
                lat_tmr_d[c] = '0;
                int_tmr_d[c] = '0;
                for (int f = 0; f < 8; f++) begin
                    cnt_d[c][f] = '0;
                end
            end
            lat_run_d  = '0;
            acc_seen_d = '0;
            overflow_d = '0;
            frozen_d   = 1'b0;
            rd_data_d  = '0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c]   <= ST_IDLE;
                outst_q[c]   <= '0;
                lat_tmr_q[c] <= '0;
                int_tmr_q[c] <= '0;
                for (int f = 0; f < 8; f++) begin
                    cnt_q[c][f] <= '0;
                end
            end
            lat_run_q  <= '0;
            acc_seen_q <= '0;
            overflow_q <= '0;
            frozen_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            outst_q    <= outst_d;
            cnt_q      <= cnt_d;
            lat_tmr_q  <= lat_tmr_d;
            int_tmr_q  <= int_tmr_d;
            lat_run_q  <= lat_run_d;
            acc_seen_q <= acc_seen_d;
            overflow_q <= overflow_d;
            frozen_q   <= frozen_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Output decode from registered state
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            active[c] = (state_q[c] != ST_IDLE);
        end
    end

    assign overflow = overflow_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed bench for ap_ctrl_perf_monitor: N_CH=3, CNT_W=8, MAX_OUT=2.
module tb_ap_ctrl_perf_monitor;

    localparam int N_CH    = 3;
    localparam int CNT_W   = 8;
    localparam int MAX_OUT = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             finish = 1'b0;
    logic             clear = 1'b0;
    logic [N_CH-1:0]  ap_start = '0;
    logic [N_CH-1:0]  ap_ready = '0;
    logic [N_CH-1:0]  ap_done = '0;
    logic [N_CH-1:0]  ap_continue = '1;
    logic [N_CH-1:0]  iter_end = '0;
    logic [1:0]       rd_ch = '0;
    logic [2:0]       rd_field = '0;
    logic [CNT_W-1:0] rd_data;
    logic [N_CH-1:0]  active;
    logic [N_CH-1:0]  overflow;

    int checks = 0;
    int errors = 0;

    ap_ctrl_perf_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT)) dut (
        .clock(clock), .reset(reset), .finish(finish), .clear(clear),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .iter_end(iter_end),
        .rd_ch(rd_ch), .rd_field(rd_field), .rd_data(rd_data),
        .active(active), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Registered read: select at a falling edge, value is valid one rising edge later
    task automatic rd_check(input string tag, input int ch, input int f, input int exp);
        rd_ch    = 2'(ch);
        rd_field = 3'(f);
        @(negedge clock);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic acc_pulse(input int ch);
        ap_start[ch] = 1'b1; ap_ready[ch] = 1'b1;
        cyc(1);
        ap_start[ch] = 1'b0; ap_ready[ch] = 1'b0;
    endtask

    task automatic cmp_pulse(input int ch);
        ap_done[ch] = 1'b1; ap_continue[ch] = 1'b1;
        cyc(1);
        ap_done[ch] = 1'b0;
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        cyc(1);
        check("reset_rd_data", 32'(rd_data), 0);
        check("reset_active", 32'(active), 0);
        check("reset_overflow", 32'(overflow), 0);

        // 1: ch0 accept, complete 15 edges later
        acc_pulse(0);
        cyc(14);
        check("t1_active_busy", 32'(active[0]), 1);
        cmp_pulse(0);
        check("t1_active_idle", 32'(active[0]), 0);
        rd_check("t1_txn", 0, 0, 1);
        rd_check("t1_done", 0, 1, 1);
        rd_check("t1_last_lat", 0, 2, 15);
        rd_check("t1_max_lat", 0, 3, 15);
        rd_check("t1_interval", 0, 4, 0);
        rd_check("t1_busy", 0, 7, 15);

        // 2: ch1 accepts every 3 edges with a 4-edge stall on the first done
        for (int e = 0; e < 10; e++) begin
            ap_start[1]    = (e == 0 || e == 3 || e == 6);
            ap_ready[1]    = ap_start[1];
            ap_done[1]     = (e >= 1 && e <= 5) || e == 8 || e == 9;
            ap_continue[1] = !(e >= 1 && e <= 4);
            cyc(1);
            if (e == 4) check("t2_active_hold", 32'(active[1]), 1);
            if (e == 5) check("t2_active_after_cmp", 32'(active[1]), 1);
        end
        ap_start[1] = 1'b0; ap_ready[1] = 1'b0; ap_done[1] = 1'b0; ap_continue[1] = 1'b1;
        check("t2_active_final", 32'(active[1]), 0);
        rd_check("t2_txn", 1, 0, 3);
        rd_check("t2_done", 1, 1, 3);
        rd_check("t2_last_lat", 1, 2, 5);
        rd_check("t2_interval", 1, 4, 3);
        rd_check("t2_stall", 1, 5, 4);
        rd_check("t2_busy", 1, 7, 9);
        check("t2_overflow", 32'(overflow[1]), 0);
        rd_check("t2_ch0_txn", 0, 0, 1);

        // 3: ch2 three accepts with MAX_OUT=2, then drain and one stray done
        acc_pulse(2);
        acc_pulse(2);
        check("t3_no_ovf_yet", 32'(overflow[2]), 0);
        acc_pulse(2);
        check("t3_overflow", 32'(overflow[2]), 1);
        cmp_pulse(2);
        check("t3_still_active", 32'(active[2]), 1);
        cmp_pulse(2);
        check("t3_idle", 32'(active[2]), 0);
        cmp_pulse(2);
        rd_check("t3_txn", 2, 0, 3);
        rd_check("t3_done", 2, 1, 2);
        rd_check("t3_last_lat", 2, 2, 3);

        // 4: 300 iteration strobes on ch0 saturate at 255
        check("t4_ovf_before", 32'(overflow[0]), 0);
        iter_end[0] = 1'b1;
        cyc(300);
        iter_end[0] = 1'b0;
        rd_check("t4_iter", 0, 6, 255);
        check("t4_overflow", 32'(overflow[0]), 1);
        rd_check("t4_ch1_iter", 1, 6, 0);
        check("t4_ch1_ovf", 32'(overflow[1]), 0);

        // 5: clear, then freeze on the same edge as an accept
        clear = 1'b1; cyc(1); clear = 1'b0;
        check("t5_clr_ovf", 32'(overflow), 0);
        rd_check("t5_clr_iter", 0, 6, 0);
        rd_check("t5_clr_txn2", 2, 0, 0);
        finish = 1'b1; ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        cyc(1);
        finish = 1'b0; ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        ap_done[0] = 1'b1; iter_end = '1; ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
        cyc(2);
        ap_done[0] = 1'b0; iter_end = '0; ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
        rd_check("t5_frz_txn", 0, 0, 1);
        rd_check("t5_frz_done", 0, 1, 0);
        rd_check("t5_frz_iter", 0, 6, 0);
        rd_check("t5_frz_ch1_txn", 1, 0, 0);
        check("t5_frz_active", 32'(active), 32'b001);
        clear = 1'b1; finish = 1'b1;
        cyc(1);
        clear = 1'b0; finish = 1'b0;
        check("t5_clr_active", 32'(active), 0);
        acc_pulse(1);
        rd_check("t5_resume_ch1_txn", 1, 0, 1);
        rd_check("t5_resume_ch0_txn", 0, 0, 0);
        check("t5_resume_active", 32'(active), 32'b010);

        // 6: async reset between edges while ch1 is busy
        rd_ch = 2'd1; rd_field = 3'd7;
        cyc(3);
        check("t6_busy_nonzero", 32'(rd_data != '0), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_active", 32'(active), 0);
        check("t6_rst_rd_data", 32'(rd_data), 0);
        cyc(1);
        reset = 1'b0;
        rd_check("t6_busy_cleared", 1, 7, 0);
        acc_pulse(0);
        rd_check("t6_ch0_txn", 0, 0, 1);
        rd_check("t6_bad_ch", 3, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
